// File: rtl/wb_merge_queue.sv
// wb_merge_queue
// Write-back merge queue: gathers up to nLANES same-cycle register writes,
// serialises them onto the single register-file write port in acceptance
// order (lane order within a group), and answers pending-write lookups so
// operand fetch can stall on registers with writes still in flight.
//
// Build option: define WBQ_DEDUP_EN to enqueue only the highest-numbered
// lane among valid lanes of one group that share an address.
module wb_merge_queue #(
    parameter int MEMD    = 16,
    parameter int DATAW   = 32,
    parameter int nLANES  = 4,
    parameter int QDEPTH  = 8,
    parameter int nQPORTS = 3,
    localparam int ADDRW  = $clog2(MEMD),
    localparam int CNTW   = $clog2(QDEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [nLANES-1:0]        InValid,
    input  logic [ADDRW*nLANES-1:0]  InAddr,
    input  logic [DATAW*nLANES-1:0]  InData,
    output logic                     InReady,
    output logic                     WEnb,
    output logic [ADDRW-1:0]         WAddr,
    output logic [DATAW-1:0]         WData,
    input  logic [ADDRW*nQPORTS-1:0] QAddr,
    output logic [nQPORTS-1:0]       QPend,
    output logic [CNTW-1:0]          Count
);

    // Pointers index QDEPTH (power of two) slots, so they wrap for free.
    localparam int PTRW = CNTW - 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(QDEPTH);
    localparam logic [CNTW-1:0] LANES_C = CNTW'(nLANES);
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    // Queue state (stage p0): storage, pointers and occupancy.
    logic [ADDRW-1:0] q_addr_p0 [QDEPTH];
    logic [DATAW-1:0] q_data_p0 [QDEPTH];
    logic [PTRW-1:0]  head_p0;
    logic [PTRW-1:0]  tail_p0;
    logic [CNTW-1:0]  count_p0;

    // Write-port register (stage p1).
    logic             wr_vld_p1;
    logic [ADDRW-1:0] wr_addr_p1;
    logic [DATAW-1:0] wr_data_p1;

    logic [nLANES-1:0] keep;
    logic [CNTW-1:0]   lane_off [nLANES];
    logic [PTRW-1:0]   slot     [nLANES];
    logic [CNTW-1:0]   nkeep;
    logic [CNTW-1:0]   enq_n;
    logic [CNTW-1:0]   free_n;
    logic [QDEPTH-1:0] occ;
    logic              accept;
    logic              drain;

    function automatic logic [ADDRW-1:0] lane_addr(input logic [ADDRW*nLANES-1:0] bus,
                                                  input int idx);
        return bus[idx*ADDRW +: ADDRW];
    endfunction

    function automatic logic [DATAW-1:0] lane_data(input logic [DATAW*nLANES-1:0] bus,
                                                  input int idx);
        return bus[idx*DATAW +: DATAW];
    endfunction

    // Ready depends only on the occupancy register, never on InValid.
    assign free_n  = DEPTH_C - count_p0;
    assign InReady = rst_n & (free_n >= LANES_C);
    assign accept  = InReady;
    // Only entries already present at the edge may drain.
    assign drain   = (count_p0 != '0);
    assign enq_n   = accept ? nkeep : '0;

    // Select which valid lanes are written into the queue.
    always_comb begin
        keep = '0;
        for (int i = 0; i < nLANES; i++) begin
            keep[i] = InValid[i];
`ifdef WBQ_DEDUP_EN
            for (int k = i + 1; k < nLANES; k++) begin
                if (InValid[k] && (lane_addr(InAddr, k) == lane_addr(InAddr, i))) begin
                    keep[i] = 1'b0;
                end
            end
`endif
        end
    end

    // Compact kept lanes: each lane's slot offset is the count of kept lanes below it.
    always_comb begin : compact
        logic [CNTW-1:0] acc;
        acc = '0;
        for (int i = 0; i < nLANES; i++) begin
            lane_off[i] = acc;
            slot[i]     = tail_p0 + lane_off[i][PTRW-1:0];
            acc         = acc + CNTW'(keep[i]);
        end
        nkeep = acc;
    end

    // Mark the slots that currently hold a queued write.
    always_comb begin : occupancy
        logic [PTRW-1:0] rel;
        occ = '0;
        for (int e = 0; e < QDEPTH; e++) begin
            rel    = PTRW'(e) - head_p0;
            occ[e] = ({1'b0, rel} < count_p0);
        end
    end

    // Pending lookup against queued entries and the write-port register.
    always_comb begin
        QPend = '0;
        for (int j = 0; j < nQPORTS; j++) begin
            if (wr_vld_p1 && (wr_addr_p1 == QAddr[j*ADDRW +: ADDRW])) begin
                QPend[j] = 1'b1;
            end
            for (int e = 0; e < QDEPTH; e++) begin
                if (occ[e] && (q_addr_p0[e] == QAddr[j*ADDRW +: ADDRW])) begin
                    QPend[j] = 1'b1;
                end
            end
        end
    end

    // Queue storage write: payload only, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < nLANES; i++) begin
                if (keep[i]) begin
                    q_addr_p0[slot[i]] <= lane_addr(InAddr, i);
                    q_data_p0[slot[i]] <= lane_data(InData, i);
                end
            end
        end
    end

    // Pointer and occupancy update; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else begin
            if (accept) begin
                tail_p0 <= tail_p0 + nkeep[PTRW-1:0];
            end
            if (drain) begin
                head_p0 <= head_p0 + PTR_ONE;
            end
            count_p0 <= count_p0 + enq_n - CNTW'(drain);
        end
    end

    // ---- stage p0 -> p1: head entry onto the register-file write port ----
    // Address/data hold their last value when nothing drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= drain;
            if (drain) begin
                wr_addr_p1 <= q_addr_p0[head_p0];
                wr_data_p1 <= q_data_p0[head_p0];
            end
        end
    end

    assign WEnb  = wr_vld_p1;
    assign WAddr = wr_addr_p1;
    assign WData = wr_data_p1;
    assign Count = count_p0;

endmodule
